// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - clocked four-vector stimulus and truth-table checker for a 2-input gate
module gate_test_sequencer #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] TRUTH       = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    ab_q, ab_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ab_q    <= 2'd0;
      cnt_q   <= '0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
      ab_d    = 2'd0;
      cnt_d   = '0;
      fail_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_APPLY;
            idx_d   = 2'd0;
            ab_d    = 2'd0;
            cnt_d   = '0;
            fail_d  = 4'd0;
          end
        end
        S_APPLY: begin
          // start is deliberately ignored here so a run cannot be restarted mid-way
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            fail_d[idx_q] = (y != TRUTH[idx_q]);
            cnt_d         = '0;
            if (idx_q == 2'd3) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + 2'd1;
              ab_d  = idx_q + 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign A         = ab_q[1];
  assign B         = ab_q[0];
  assign busy      = (state_q == S_APPLY);
  assign done      = (state_q == S_DONE);
  assign pass      = done & (fail_q == 4'd0);
  assign fail_mask = fail_q;
  assign vec_idx   = idx_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - scoreboard bench for gate_test_sequencer with H=4 and H=1 instances
module tb_gate_test_sequencer;

  localparam logic [3:0] TT = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, abort;
  logic [1:0]      start;
  logic [1:0][3:0] tbl;
  logic [1:0]      a, b, busy, done, pass, yv;
  logic [1:0][3:0] fm;
  logic [1:0][1:0] vi;

  int passed = 0;
  int total  = 0;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  assign yv[0] = tbl[0][{a[0], b[0]}];
  assign yv[1] = tbl[1][{a[1], b[1]}];

  gate_test_sequencer #(.HOLD_CYCLES(4), .TRUTH(TT)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .y(yv[0]),
    .A(a[0]), .B(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_mask(fm[0]), .vec_idx(vi[0])
  );

  gate_test_sequencer #(.HOLD_CYCLES(1), .TRUTH(TT)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(1'b0), .y(yv[1]),
    .A(a[1]), .B(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_mask(fm[1]), .vec_idx(vi[1])
  );

  function automatic int hold(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic chk_zero(int i, string tag);
    chk({tag, "_A"}, 32'(a[i]), 0);
    chk({tag, "_B"}, 32'(b[i]), 0);
    chk({tag, "_busy"}, 32'(busy[i]), 0);
    chk({tag, "_done"}, 32'(done[i]), 0);
    chk({tag, "_pass"}, 32'(pass[i]), 0);
    chk({tag, "_fail_mask"}, 32'(fm[i]), 0);
    chk({tag, "_vec_idx"}, 32'(vi[i]), 0);
  endtask

  // Monitor: per busy cycle k the applied vector is k/H; on done rising pop the expected mask
  initial begin
    int         bcnt[2];
    logic [1:0] busy_p, done_p;
    logic [3:0] e;
    busy_p = '0;
    done_p = '0;
    bcnt[0] = 0;
    bcnt[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_p = '0;
        done_p = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (busy[i]) begin
            if (!busy_p[i]) begin
              bcnt[i] = 0;
              chk("fail_mask_cleared_at_start", 32'(fm[i]), 0);
            end
            chk("applied_vector", 32'({a[i], b[i]}), 32'(bcnt[i] / hold(i)));
            chk("vec_idx", 32'(vi[i]), 32'(bcnt[i] / hold(i)));
            bcnt[i]++;
          end
          if (done[i] && !done_p[i]) begin
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
              chk("unexpected_done", 32'(done[i]), 0);
            end else begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk("fail_mask", 32'(fm[i]), 32'(e));
              chk("pass", 32'(pass[i]), 32'(e == 4'd0));
              chk("busy_cycles", 32'(bcnt[i]), 32'(4 * hold(i)));
              chk("busy_low_in_done", 32'(busy[i]), 0);
            end
          end
          busy_p[i] = busy[i];
          done_p[i] = done[i];
        end
      end
    end
  end

  task automatic wait_done(int i);
    for (int k = 0; k < 200 && !done[i]; k++) begin
      @(posedge clk);
      #2;
    end
    chk("done_within_budget", 32'(done[i]), 1);
    @(negedge clk);
    #1;
  endtask

  // Expected mask: vector v mismatches when the gate's output differs from the table bit
  task automatic run(int i, logic [3:0] gate, int mid_start);
    tbl[i] = gate;
    if (i == 0) exp_q0.push_back(gate ^ TT);
    else        exp_q1.push_back(gate ^ TT);
    @(posedge clk); #2 start[i] = 1'b1;
    @(posedge clk); #2 start[i] = 1'b0;
    if (mid_start > 0) begin
      repeat (mid_start - 1) @(posedge clk);
      #2 start[i] = 1'b1;
      @(posedge clk); #2 start[i] = 1'b0;
    end
    wait_done(i);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    start = '0;
    tbl   = '0;
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run(0, 4'b0001, 0);
    run(0, 4'b0111, 0);
    run(0, 4'b0111, 0);
    run(1, 4'b0000, 0);
    run(0, 4'b0001, 6);
    run(1, 4'b1000, 0);
    for (int n = 0; n < 6; n++) begin
      run(0, 4'($urandom), 0);
      run(1, 4'($urandom), ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    tbl[0] = 4'b0001;
    exp_q0.push_back(4'b0000);
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    repeat (8) @(posedge clk);
    #2 abort = 1'b1; start[0] = 1'b1;
    @(posedge clk); #2 abort = 1'b0; start[0] = 1'b0;
    exp_q0.delete();
    chk_zero(0, "abort_mid_run");

    #2 abort = 1'b1; start[0] = 1'b1;
    @(posedge clk); #2 abort = 1'b0; start[0] = 1'b0;
    chk_zero(0, "abort_beats_start");

    exp_q0.push_back(4'b0000);
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_q0.delete();
    chk_zero(0, "async_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    run(0, 4'b0001, 0);
    chk("pass_after_reset", 32'(pass[0]), 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
